// File: rtl/tl_scratchpad_responder.sv
// TileLink-UL/UH manager endpoint backed by a 64-bit-wide scratchpad.
// One transaction in flight; Get/Put single and multi-beat, denied otherwise.
module tl_scratchpad_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int MAX_SIZE    = 6,
    parameter int SINK_ID     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_a_valid,
    output logic        io_a_ready,
    input  logic [2:0]  io_a_bits_opcode,
    input  logic [2:0]  io_a_bits_param,
    input  logic [3:0]  io_a_bits_size,
    input  logic [4:0]  io_a_bits_source,
    input  logic [31:0] io_a_bits_address,
    input  logic [7:0]  io_a_bits_mask,
    input  logic [63:0] io_a_bits_data,
    input  logic        io_a_bits_corrupt,
    output logic        io_d_valid,
    input  logic        io_d_ready,
    output logic [2:0]  io_d_bits_opcode,
    output logic [1:0]  io_d_bits_param,
    output logic [3:0]  io_d_bits_size,
    output logic [4:0]  io_d_bits_source,
    output logic [2:0]  io_d_bits_sink,
    output logic        io_d_bits_denied,
    output logic [63:0] io_d_bits_data,
    output logic        io_d_bits_corrupt
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] MAX_SZ = 4'(MAX_SIZE);
    localparam logic [2:0] SINK = 3'(SINK_ID);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_ARITH    = 3'd2;
    localparam logic [2:0] OP_LOGIC    = 3'd3;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_HINT     = 3'd5;

    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESP_DATA,
        RESP_ACK
    } state_t;

    state_t          state;
    logic [2:0]      beat;
    logic [2:0]      last;
    logic [AW-1:0]   base;
    logic            denied;
    logic            a_ready;
    logic            d_valid;
    logic [2:0]      d_opcode;
    logic [3:0]      d_size;
    logic [4:0]      d_source;
    logic            d_denied;
    logic            d_corrupt;

    logic [63:0]     mem [DEPTH_WORDS];

    logic            a_fire;
    logic            d_fire;
    logic            a_denied;
    logic [AW-1:0]   a_idx;
    logic [2:0]      a_last;
    logic            a_is_write;
    logic [AW-1:0]   rd_idx;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic            unused_ok;

    // Index of the last beat (beats - 1) for a given log2 transfer size.
    function automatic logic [2:0] last_beat(input logic [3:0] sz);
        if (sz <= 4'd3) begin
            return 3'd0;
        end else if (sz == 4'd4) begin
            return 3'd1;
        end else if (sz == 4'd5) begin
            return 3'd3;
        end else begin
            return 3'd7;
        end
    endfunction

    assign a_fire     = io_a_valid & a_ready;
    assign d_fire     = d_valid & io_d_ready;
    assign a_idx      = io_a_bits_address[AW+2:3];
    assign a_last     = last_beat(io_a_bits_size);
    assign a_is_write = ~io_a_bits_opcode[2];
    assign rd_idx     = base + AW'(beat);
    assign unused_ok  = ^{io_a_bits_param, io_a_bits_address[2:0]};

    // Request legality: address range, size limit and supported opcodes.
    always_comb begin
        a_denied = 1'b0;
        if (|io_a_bits_address[31:AW+3]) begin
            a_denied = 1'b1;
        end
        if (io_a_bits_size > MAX_SZ) begin
            a_denied = 1'b1;
        end
        unique case (io_a_bits_opcode)
            OP_ARITH, OP_LOGIC, 3'd6, 3'd7: a_denied = 1'b1;
            default: ;
        endcase
    end

    // Scratchpad write port: first beat from IDLE, later beats from WRITE.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = a_idx;
        if (a_fire && !io_a_bits_corrupt) begin
            if (state == IDLE) begin
                wr_en = a_is_write & ~a_denied;
            end else if (state == WRITE) begin
                wr_en  = ~denied;
                wr_idx = base + AW'(beat);
            end
        end
    end

    // Byte-masked scratchpad storage; contents are not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (io_a_bits_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= io_a_bits_data[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered handshake and D header outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            beat      <= 3'd0;
            last      <= 3'd0;
            base      <= '0;
            denied    <= 1'b0;
            a_ready   <= 1'b1;
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 4'd0;
            d_source  <= 5'd0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (a_fire) begin
                        base     <= a_idx;
                        last     <= a_last;
                        denied   <= a_denied;
                        beat     <= 3'd0;
                        d_size   <= io_a_bits_size;
                        d_source <= io_a_bits_source;
                        d_denied <= a_denied;
                        unique case (io_a_bits_opcode)
                            OP_PUT_FULL, OP_PUT_PART,
                            OP_ARITH, OP_LOGIC: begin
                                d_opcode  <= D_ACK;
                                d_corrupt <= 1'b0;
                                if (a_last == 3'd0) begin
                                    state   <= RESP_ACK;
                                    a_ready <= 1'b0;
                                    d_valid <= 1'b1;
                                end else begin
                                    state <= WRITE;
                                    beat  <= 3'd1;
                                end
                            end
                            OP_HINT: begin
                                state     <= RESP_ACK;
                                a_ready   <= 1'b0;
                                d_valid   <= 1'b1;
                                d_opcode  <= D_HINT_ACK;
                                d_corrupt <= 1'b0;
                            end
                            default: begin
                                state     <= RESP_DATA;
                                a_ready   <= 1'b0;
                                d_valid   <= 1'b1;
                                d_opcode  <= D_ACK_DATA;
                                d_corrupt <= a_denied;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (a_fire) begin
                        beat <= beat + 3'd1;
                        if (beat == last) begin
                            state   <= RESP_ACK;
                            a_ready <= 1'b0;
                            d_valid <= 1'b1;
                        end
                    end
                end
                RESP_DATA: begin
                    if (d_fire) begin
                        if (beat == last) begin
                            state     <= IDLE;
                            beat      <= 3'd0;
                            a_ready   <= 1'b1;
                            d_valid   <= 1'b0;
                            d_opcode  <= 3'd0;
                            d_size    <= 4'd0;
                            d_source  <= 5'd0;
                            d_denied  <= 1'b0;
                            d_corrupt <= 1'b0;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                RESP_ACK: begin
                    if (d_fire) begin
                        state     <= IDLE;
                        beat      <= 3'd0;
                        a_ready   <= 1'b1;
                        d_valid   <= 1'b0;
                        d_opcode  <= 3'd0;
                        d_size    <= 4'd0;
                        d_source  <= 5'd0;
                        d_denied  <= 1'b0;
                        d_corrupt <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    a_ready <= 1'b1;
                    d_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_a_ready        = a_ready;
    assign io_d_valid        = d_valid;
    assign io_d_bits_opcode  = d_opcode;
    assign io_d_bits_param   = 2'd0;
    assign io_d_bits_size    = d_size;
    assign io_d_bits_source  = d_source;
    assign io_d_bits_sink    = SINK;
    assign io_d_bits_denied  = d_denied;
    assign io_d_bits_corrupt = d_corrupt;
    assign io_d_bits_data    = (state == RESP_DATA && !denied) ? mem[rd_idx] : 64'd0;

endmodule

// File: tb/tb_tl_scratchpad_responder.sv
// Directed bench for tl_scratchpad_responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tl_scratchpad_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_a_valid = 1'b0;
    logic        io_a_ready;
    logic [2:0]  io_a_bits_opcode = '0;
    logic [2:0]  io_a_bits_param = '0;
    logic [3:0]  io_a_bits_size = '0;
    logic [4:0]  io_a_bits_source = '0;
    logic [31:0] io_a_bits_address = '0;
    logic [7:0]  io_a_bits_mask = '0;
    logic [63:0] io_a_bits_data = '0;
    logic        io_a_bits_corrupt = 1'b0;
    logic        io_d_valid;
    logic        io_d_ready = 1'b0;
    logic [2:0]  io_d_bits_opcode;
    logic [1:0]  io_d_bits_param;
    logic [3:0]  io_d_bits_size;
    logic [4:0]  io_d_bits_source;
    logic [2:0]  io_d_bits_sink;
    logic        io_d_bits_denied;
    logic [63:0] io_d_bits_data;
    logic        io_d_bits_corrupt;

    int total = 0;
    int bad = 0;

    tl_scratchpad_responder dut (
        .clock             (clock),
        .reset             (reset),
        .io_a_valid        (io_a_valid),
        .io_a_ready        (io_a_ready),
        .io_a_bits_opcode  (io_a_bits_opcode),
        .io_a_bits_param   (io_a_bits_param),
        .io_a_bits_size    (io_a_bits_size),
        .io_a_bits_source  (io_a_bits_source),
        .io_a_bits_address (io_a_bits_address),
        .io_a_bits_mask    (io_a_bits_mask),
        .io_a_bits_data    (io_a_bits_data),
        .io_a_bits_corrupt (io_a_bits_corrupt),
        .io_d_valid        (io_d_valid),
        .io_d_ready        (io_d_ready),
        .io_d_bits_opcode  (io_d_bits_opcode),
        .io_d_bits_param   (io_d_bits_param),
        .io_d_bits_size    (io_d_bits_size),
        .io_d_bits_source  (io_d_bits_source),
        .io_d_bits_sink    (io_d_bits_sink),
        .io_d_bits_denied  (io_d_bits_denied),
        .io_d_bits_data    (io_d_bits_data),
        .io_d_bits_corrupt (io_d_bits_corrupt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One A beat; called on a falling edge, returns on the next one.
    task automatic a_send(input logic [2:0] op, input logic [3:0] sz,
                          input logic [4:0] src, input logic [31:0] adr,
                          input logic [7:0] msk, input logic [63:0] dat,
                          input logic cor);
        chk("a_ready", io_a_ready, 1);
        io_a_valid        = 1'b1;
        io_a_bits_opcode  = op;
        io_a_bits_size    = sz;
        io_a_bits_source  = src;
        io_a_bits_address = adr;
        io_a_bits_mask    = msk;
        io_a_bits_data    = dat;
        io_a_bits_corrupt = cor;
        @(negedge clock);
        io_a_valid        = 1'b0;
        io_a_bits_corrupt = 1'b0;
    endtask

    // Check the presented D beat, then accept it.
    task automatic d_take(input logic [2:0] op, input logic [3:0] sz,
                          input logic [4:0] src, input logic den,
                          input logic cor, input logic [63:0] dat,
                          input bit use_dat);
        chk("d_valid", io_d_valid, 1);
        chk("d_opcode", io_d_bits_opcode, op);
        chk("d_size", io_d_bits_size, sz);
        chk("d_source", io_d_bits_source, src);
        chk("d_denied", io_d_bits_denied, den);
        chk("d_corrupt", io_d_bits_corrupt, cor);
        chk("d_param", io_d_bits_param, 0);
        chk("d_sink", io_d_bits_sink, 0);
        chk("a_ready_busy", io_a_ready, 0);
        if (use_dat) chk("d_data", io_d_bits_data, dat);
        io_d_ready = 1'b1;
        @(negedge clock);
        io_d_ready = 1'b0;
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_d_valid", io_d_valid, 0);
        chk("rst_d_opcode", io_d_bits_opcode, 0);
        chk("rst_d_size", io_d_bits_size, 0);
        chk("rst_d_source", io_d_bits_source, 0);
        chk("rst_d_denied", io_d_bits_denied, 0);
        chk("rst_d_data", io_d_bits_data, 0);
        chk("rst_d_sink", io_d_bits_sink, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rel_a_ready", io_a_ready, 1);

        // single-beat PutFull then Get
        a_send(3'd0, 4'd3, 5'd3, 32'h10, 8'hFF, 64'h1122334455667788, 0);
        d_take(3'd0, 4'd3, 5'd3, 0, 0, 0, 0);
        a_send(3'd4, 4'd3, 5'd4, 32'h10, 8'h00, 0, 0);
        d_take(3'd1, 4'd3, 5'd4, 0, 0, 64'h1122334455667788, 1);

        // 8-beat PutFull of data k to words 8..15
        for (int k = 0; k < 8; k++) begin
            a_send(3'd0, 4'd6, 5'd2, 32'h40, 8'hFF, 64'(k), 0);
        end
        d_take(3'd0, 4'd6, 5'd2, 0, 0, 0, 0);

        // 8-beat Get with d_ready toggling; stalled beat must hold
        a_send(3'd4, 4'd6, 5'd9, 32'h40, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++) begin
            chk("burst_valid", io_d_valid, 1);
            chk("burst_data", io_d_bits_data, 64'(k));
            chk("burst_size", io_d_bits_size, 6);
            chk("burst_a_ready", io_a_ready, 0);
            io_d_ready = 1'b1;
            @(negedge clock);
            io_d_ready = 1'b0;
            if (k < 7) begin
                chk("stall_valid", io_d_valid, 1);
                chk("stall_data", io_d_bits_data, 64'(k + 1));
                chk("stall_a_ready", io_a_ready, 0);
                @(negedge clock);
            end
        end
        chk("burst_end_valid", io_d_valid, 0);
        chk("burst_end_a_ready", io_a_ready, 1);

        // PutPartial over low four bytes
        a_send(3'd1, 4'd3, 5'd1, 32'h10, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 0);
        d_take(3'd0, 4'd3, 5'd1, 0, 0, 0, 0);
        a_send(3'd4, 4'd3, 5'd1, 32'h10, 8'h00, 0, 0);
        d_take(3'd1, 4'd3, 5'd1, 0, 0, 64'h11223344FFFFFFFF, 1);

        // out-of-range Get and Put; word 0 must be unaffected
        a_send(3'd0, 4'd3, 5'd0, 32'h0, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 0);
        d_take(3'd0, 4'd3, 5'd0, 0, 0, 0, 0);
        a_send(3'd4, 4'd4, 5'd6, 32'h100, 8'h00, 0, 0);
        d_take(3'd1, 4'd4, 5'd6, 1, 1, 0, 1);
        d_take(3'd1, 4'd4, 5'd6, 1, 1, 0, 1);
        chk("oor_done_valid", io_d_valid, 0);
        a_send(3'd0, 4'd3, 5'd6, 32'h100, 8'hFF, 64'hDEADBEEFDEADBEEF, 0);
        d_take(3'd0, 4'd3, 5'd6, 1, 0, 0, 0);
        a_send(3'd4, 4'd3, 5'd6, 32'h0, 8'h00, 0, 0);
        d_take(3'd1, 4'd3, 5'd6, 0, 0, 64'hA5A5A5A5A5A5A5A5, 1);

        // Hint and Arithmetic
        a_send(3'd5, 4'd0, 5'd7, 32'h0, 8'h00, 0, 0);
        d_take(3'd2, 4'd0, 5'd7, 0, 0, 0, 0);
        a_send(3'd2, 4'd3, 5'd8, 32'h10, 8'hFF, 64'h0, 0);
        d_take(3'd0, 4'd3, 5'd8, 1, 0, 0, 0);
        a_send(3'd4, 4'd3, 5'd8, 32'h10, 8'h00, 0, 0);
        d_take(3'd1, 4'd3, 5'd8, 0, 0, 64'h11223344FFFFFFFF, 1);

        // corrupt beat is dropped, ack not denied
        a_send(3'd0, 4'd3, 5'd10, 32'h18, 8'hFF, 64'h0123456789ABCDEF, 0);
        d_take(3'd0, 4'd3, 5'd10, 0, 0, 0, 0);
        a_send(3'd0, 4'd3, 5'd10, 32'h18, 8'hFF, 64'hFFFF0000FFFF0000, 1);
        d_take(3'd0, 4'd3, 5'd10, 0, 0, 0, 0);
        a_send(3'd4, 4'd3, 5'd10, 32'h18, 8'h00, 0, 0);
        d_take(3'd1, 4'd3, 5'd10, 0, 0, 64'h0123456789ABCDEF, 1);

        // size above MAX_SIZE: denied, 8 beats
        a_send(3'd4, 4'd7, 5'd11, 32'h0, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++) begin
            d_take(3'd1, 4'd7, 5'd11, 1, 1, 0, 1);
        end
        chk("big_done_valid", io_d_valid, 0);

        // reset during beat 3 of an 8-beat Get
        a_send(3'd4, 4'd6, 5'd5, 32'h40, 8'h00, 0, 0);
        io_d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("pre_rst_data", io_d_bits_data, 64'(k));
            @(negedge clock);
        end
        io_d_ready = 1'b0;
        chk("beat3_valid", io_d_valid, 1);
        chk("beat3_data", io_d_bits_data, 64'd3);
        reset = 1'b0;
        #1;
        chk("abort_valid", io_d_valid, 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("post_rst_a_ready", io_a_ready, 1);
        chk("post_rst_valid", io_d_valid, 0);
        @(negedge clock);
        a_send(3'd4, 4'd3, 5'd12, 32'h48, 8'h00, 0, 0);
        d_take(3'd1, 4'd3, 5'd12, 0, 0, 64'd1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
